gcd_host_sequencer: RTL and testbench

GCD_HOST_SEQUENCER -- requirements
Module: gcd_host_sequencer

---
 rtl/gcd_host_sequencer.sv | 99 +++++++++
 tb/tb_gcd_host_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_host_sequencer.sv
// Host-side sequencer for a serial-load GCD datapath/controller pair:
// accepts operand pairs, streams A then B, waits for done (bounded), returns the result.
module gcd_host_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic [15:0]      jobs_done
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LDA, LDB, WAIT, RESP} state_t;

  state_t           state, next;
  logic [WIDTH-1:0] reg_a, reg_b;
  logic [CW-1:0]    cnt;
  logic             accept, zero_pair, timeout_hit, consume;

  assign accept      = (state == IDLE) && op_valid;
  assign zero_pair   = (op_a == '0) || (op_b == '0);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign consume     = (state == RESP) && res_ready;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = zero_pair ? RESP : LDA;
      LDA:     next = LDB;
      LDB:     next = WAIT;
      WAIT:    if (gcd_done || timeout_hit) next = RESP;
      RESP:    if (consume) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == IDLE);
    gcd_start = (state == LDA) || (state == LDB) || (state == WAIT);
    gcd_data  = '0;
    case (state)
      LDA:       gcd_data = reg_a;
      LDB, WAIT: gcd_data = reg_b;
      default:   gcd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      reg_a     <= '0;
      reg_b     <= '0;
      cnt       <= '0;
      res_gcd   <= '0;
      res_err   <= 1'b0;
      jobs_done <= '0;
    end else begin
      state     <= next;
      res_valid <= (next == RESP);
      if (accept) begin
        reg_a <= op_a;
        reg_b <= op_b;
        if (zero_pair) begin
          res_gcd <= op_a | op_b;
          res_err <= 1'b0;
        end
      end
      if (state == LDB) cnt <= '0;
      // done is checked before the timeout so a coinciding done is never reported as an error
      if (state == WAIT) begin
        if (gcd_done) begin
          res_gcd <= gcd_result;
          res_err <= 1'b0;
        end else if (timeout_hit) begin
          res_gcd <= '0;
          res_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (consume && !res_err) jobs_done <= jobs_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed self-checking bench for gcd_host_sequencer with a behavioural GCD model
// whose done timing is selectable per job.
module tb_gcd_host_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n, op_valid, op_ready, res_valid, res_ready, res_err;
  logic [W-1:0]  op_a, op_b, res_gcd, gcd_data, gcd_result;
  logic          gcd_start, gcd_done;
  logic [15:0]   jobs_done;

  gcd_host_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_gcd(res_gcd), .res_err(res_err), .gcd_start(gcd_start),
    .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result),
    .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Behavioural GCD: captures A/B on the first two start cycles, raises done
  // combinationally in WAIT cycle number done_at (1-based) when enabled.
  logic          done_en;
  int            done_at;
  int            sc;
  logic [W-1:0]  cap_a, cap_b;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, t;
    a = x; b = y;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  always @(posedge clk) begin
    if (gcd_start) begin
      if (sc == 0) cap_a <= gcd_data;
      if (sc == 1) cap_b <= gcd_data;
      sc <= sc + 1;
    end else begin
      sc <= 0;
    end
  end

  assign gcd_result = gcd_f(cap_a, cap_b);
  assign gcd_done   = done_en && gcd_start && (sc == done_at + 1);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!res_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq({tag, "_res_valid_seen"}, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a = a; op_b = b; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    sc = 0; cap_a = '0; cap_b = '0;
    done_en = 1'b0; done_at = 3;
    rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rst_gcd_start", {31'd0, gcd_start}, 32'd0);
    check_eq("rst_gcd_data", {16'd0, gcd_data}, 32'd0);
    check_eq("rst_jobs", {16'd0, jobs_done}, 32'd0);
    check_eq("rst_res_gcd", {16'd0, res_gcd}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_op_ready", {31'd0, op_ready}, 32'd1);

    // (143,78): A then B on consecutive start cycles
    done_en = 1'b1; done_at = 3;
    offer(16'd143, 16'd78);
    check_eq("p1_lda_start", {31'd0, gcd_start}, 32'd1);
    check_eq("p1_lda_data", {16'd0, gcd_data}, 32'd143);
    check_eq("p1_op_ready_busy", {31'd0, op_ready}, 32'd0);
    tick();
    check_eq("p1_ldb_data", {16'd0, gcd_data}, 32'd78);
    wait_res("p1", 30);
    check_eq("p1_gcd", {16'd0, res_gcd}, 32'd13);
    check_eq("p1_err", {31'd0, res_err}, 32'd0);
    consume();
    check_eq("p1_res_valid_drop", {31'd0, res_valid}, 32'd0);
    check_eq("p1_jobs", {16'd0, jobs_done}, 32'd1);

    // zero-operand shortcut
    offer(16'd0, 16'd36);
    check_eq("z1_no_start", {31'd0, gcd_start}, 32'd0);
    check_eq("z1_res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("z1_gcd", {16'd0, res_gcd}, 32'd36);
    consume();
    offer(16'd0, 16'd0);
    check_eq("z2_no_start", {31'd0, gcd_start}, 32'd0);
    check_eq("z2_res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("z2_gcd", {16'd0, res_gcd}, 32'd0);
    consume();
    check_eq("z_jobs", {16'd0, jobs_done}, 32'd3);

    // timeout: LDA, LDB then 8 WAIT cycles -> error visible after 10 edges
    done_en = 1'b0;
    offer(16'd9, 16'd6);
    for (int i = 0; i < 9; i++) tick();
    check_eq("to_not_yet", {31'd0, res_valid}, 32'd0);
    tick();
    check_eq("to_res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("to_err", {31'd0, res_err}, 32'd1);
    check_eq("to_gcd", {16'd0, res_gcd}, 32'd0);
    consume();
    check_eq("to_jobs", {16'd0, jobs_done}, 32'd3);

    // done on the 8th WAIT cycle wins over the timeout
    done_en = 1'b1; done_at = 8;
    offer(16'd12, 16'd8);
    for (int i = 0; i < 9; i++) tick();
    check_eq("d8_not_yet", {31'd0, res_valid}, 32'd0);
    tick();
    check_eq("d8_res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("d8_err", {31'd0, res_err}, 32'd0);
    check_eq("d8_gcd", {16'd0, res_gcd}, 32'd4);
    consume();
    check_eq("d8_jobs", {16'd0, jobs_done}, 32'd4);

    // (21,21) with back-pressure
    done_at = 2;
    offer(16'd21, 16'd21);
    wait_res("bp", 30);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check_eq("bp_gcd", {16'd0, res_gcd}, 32'd21);
      check_eq("bp_op_ready", {31'd0, op_ready}, 32'd0);
      tick();
    end
    consume();
    check_eq("bp_op_ready_after", {31'd0, op_ready}, 32'd1);
    check_eq("bp_jobs", {16'd0, jobs_done}, 32'd5);

    // reset during WAIT discards the job
    done_en = 1'b0;
    offer(16'd48, 16'd18);
    tick(); tick(); tick();
    check_eq("rw_in_wait", {31'd0, gcd_start}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rw_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rw_gcd_start", {31'd0, gcd_start}, 32'd0);
    check_eq("rw_gcd_data", {16'd0, gcd_data}, 32'd0);
    check_eq("rw_jobs", {16'd0, jobs_done}, 32'd0);
    check_eq("rw_res_err", {31'd0, res_err}, 32'd0);
    check_eq("rw_op_ready", {31'd0, op_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("rw_no_result", {31'd0, res_valid}, 32'd0);
    end
    done_en = 1'b1; done_at = 2;
    offer(16'd48, 16'd18);
    wait_res("rw2", 30);
    check_eq("rw2_gcd", {16'd0, res_gcd}, 32'd6);
    consume();
    check_eq("rw2_jobs", {16'd0, jobs_done}, 32'd1);

    // stream zero-shortcut jobs (2 cycles each) up to 0xFFFF, then wrap
    op_a = 16'd0; op_b = 16'd5; op_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      tick(); tick();
    end
    check_eq("wrap_ffff", {16'd0, jobs_done}, 32'hFFFF);
    tick(); tick();
    op_valid = 1'b0; res_ready = 1'b0;
    check_eq("wrap_zero", {16'd0, jobs_done}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
